// File: rtl/icarus_fetch_pkg.sv
// Shared types for the instruction-fetch sequencing controller: FSM states,
// PC-source mux select codes and the pending-redirect kind.
package icarus_fetch_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_MEM   = 2'd1,
        WAIT_REDIR = 2'd2
    } fetch_state_e;

    // {Jump, Branch} encoding of the PC source mux; 2'b11 is never driven.
    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        PEND_NONE   = 2'd0,
        PEND_BRANCH = 2'd1,
        PEND_JUMP   = 2'd2
    } pend_kind_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Request/control bundle between the fetch controller (master) and the
// pipeline datapath (slave).
interface fetch_controller_if #(
    parameter int DEST_W = 32,
    parameter int PERF_W = 32
);
    // Requests are level signals sampled every cycle; there is no valid/ready
    // pairing, a request that is not acted on is simply re-asserted by its source.
    logic              BranchReq;
    logic [DEST_W-1:0] BranchDestIn;
    logic              JumpReq;
    logic [DEST_W-1:0] JumpDestIn;
    logic              LoadUse;
    logic              MemBusy;
    logic              PCWrite;
    logic              Jump;
    logic              Branch;
    logic [DEST_W-1:0] BranchDest;
    logic [DEST_W-1:0] JumpDest;
    logic              IFIDWrite;
    logic              IFIDFlush;
    logic              IDEXFlush;
    logic [PERF_W-1:0] StallCount;
    logic [PERF_W-1:0] FlushCount;

    modport master (
        input  BranchReq, BranchDestIn, JumpReq, JumpDestIn, LoadUse, MemBusy,
        output PCWrite, Jump, Branch, BranchDest, JumpDest,
               IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
    );

    modport slave (
        output BranchReq, BranchDestIn, JumpReq, JumpDestIn, LoadUse, MemBusy,
        input  PCWrite, Jump, Branch, BranchDest, JumpDest,
               IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
    );
endinterface

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing: PC advance/hold/redirect, IF/ID and ID/EX controls,
// redirect capture across memory waits. Perf counters built under FETCH_PERF_CNT_EN.
module fetch_controller
    import icarus_fetch_pkg::*;
#(
    parameter int DEST_W = 32,
    parameter int PERF_W = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    fetch_controller_if.master  bus,
    output fetch_state_e        dbg_state
);
    fetch_state_e      state_q, state_d;
    pend_kind_e        pend_kind_q, pend_kind_d;
    logic [DEST_W-1:0] pend_dest_q, pend_dest_d;
    pend_kind_e        rep_kind;
    logic [DEST_W-1:0] rep_dest;
    logic              pc_write, ifid_write, ifid_flush, idex_flush;
    logic [1:0]        sel;
    logic [DEST_W-1:0] branch_dest, jump_dest;
    logic [PERF_W-1:0] stall_count, flush_count;

    always_comb begin
        state_d     = state_q;
        pend_kind_d = pend_kind_q;
        pend_dest_d = pend_dest_q;
        rep_kind    = pend_kind_q;
        rep_dest    = pend_dest_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        sel         = SEL_SEQ;
        branch_dest = bus.BranchDestIn;
        jump_dest   = bus.JumpDestIn;
        if (!Reset) begin
            unique case (state_q)
                RUN, WAIT_MEM: begin
                    if (!bus.MemBusy) begin
                        state_d = RUN;
                        if (bus.BranchReq) begin
                            sel = SEL_BRANCH; pc_write = 1'b1; ifid_write = 1'b1;
                            ifid_flush = 1'b1; idex_flush = 1'b1;
                        end else if (bus.LoadUse) begin
                            idex_flush = 1'b1;
                        end else if (bus.JumpReq) begin
                            sel = SEL_JUMP; pc_write = 1'b1; ifid_write = 1'b1;
                            ifid_flush = 1'b1;
                        end else begin
                            pc_write = 1'b1; ifid_write = 1'b1;
                        end
                    end else begin
                        // Memory wait: PC holds; any redirect is captured for replay.
                        state_d = WAIT_MEM;
                        if (bus.BranchReq) begin
                            ifid_write = 1'b1; ifid_flush = 1'b1; idex_flush = 1'b1;
                            state_d = WAIT_REDIR;
                            pend_kind_d = PEND_BRANCH; pend_dest_d = bus.BranchDestIn;
                        end else if (bus.LoadUse) begin
                            idex_flush = 1'b1;
                        end else begin
                            ifid_write = 1'b1; ifid_flush = 1'b1;
                            if (bus.JumpReq) begin
                                state_d = WAIT_REDIR;
                                pend_kind_d = PEND_JUMP; pend_dest_d = bus.JumpDestIn;
                            end
                        end
                    end
                end
                WAIT_REDIR: begin
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    // ID carries only bubbles here, so only an EX branch can supersede.
                    if (bus.BranchReq) begin
                        idex_flush = 1'b1;
                        rep_kind = PEND_BRANCH;
                        rep_dest = bus.BranchDestIn;
                    end
                    pend_kind_d = rep_kind;
                    pend_dest_d = rep_dest;
                    if (!bus.MemBusy) begin
                        pc_write = 1'b1;
                        state_d = RUN;
                        if (rep_kind == PEND_BRANCH) begin
                            sel = SEL_BRANCH; branch_dest = rep_dest;
                        end else begin
                            sel = SEL_JUMP; jump_dest = rep_dest;
                        end
                        pend_kind_d = PEND_NONE;
                        pend_dest_d = '0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= RUN;
            pend_kind_q <= PEND_NONE;
            pend_dest_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_kind_q <= pend_kind_d;
            pend_dest_q <= pend_dest_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk(Clock), .rst(Reset), .inc(!pc_write && !Reset), .clear(1'b0), .count(stall_count)
    );
    sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk(Clock), .rst(Reset), .inc(ifid_flush || idex_flush), .clear(1'b0), .count(flush_count)
    );
`else
    assign stall_count = {PERF_W{1'b0}};
    assign flush_count = {PERF_W{1'b0}};
`endif

    assign bus.PCWrite    = pc_write;
    assign bus.Jump       = sel[1];
    assign bus.Branch     = sel[0];
    assign bus.BranchDest = branch_dest;
    assign bus.JumpDest   = jump_dest;
    assign bus.IFIDWrite  = ifid_write;
    assign bus.IFIDFlush  = ifid_flush;
    assign bus.IDEXFlush  = idex_flush;
    assign bus.StallCount = stall_count;
    assign bus.FlushCount = flush_count;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a redirect-queue model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_fetch_controller;
    import icarus_fetch_pkg::*;

    localparam int DEST_W = 32;
    localparam int PERF_W = 32;

    logic         Clock;
    logic         Reset;
    fetch_state_e dbg_state;
    int           checks = 0;
    int           errors = 0;

    fetch_controller_if #(.DEST_W(DEST_W), .PERF_W(PERF_W)) bus ();

    fetch_controller #(.DEST_W(DEST_W), .PERF_W(PERF_W)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- model ----------------
    // Outstanding redirect: {is_branch, target}; at most one entry.
    logic [DEST_W:0]   exp_q[$];
    logic [PERF_W-1:0] m_stall = '0;
    logic [PERF_W-1:0] m_flush = '0;
    logic              nxt_valid;
    logic [DEST_W:0]   nxt_entry;
    logic              e_pcw_c, e_flush_c;

    always @(negedge Clock) begin
        logic e_pcw, e_j, e_b, e_ifw, e_iff, e_idf;
        logic [DEST_W-1:0] e_bd, e_jd, dest;
        logic is_br;
        logic [133:0] exp_v, act_v;
        e_pcw = 0; e_j = 0; e_b = 0; e_ifw = 0; e_iff = 0; e_idf = 0;
        e_bd = bus.BranchDestIn; e_jd = bus.JumpDestIn;
        nxt_valid = 0; nxt_entry = '0;
        if (!Reset) begin
            if (exp_q.size() != 0) begin
                is_br = exp_q[0][DEST_W];
                dest  = exp_q[0][DEST_W-1:0];
                if (bus.BranchReq) begin
                    is_br = 1; dest = bus.BranchDestIn; e_idf = 1;
                end
                e_ifw = 1; e_iff = 1;
                if (!bus.MemBusy) begin
                    e_pcw = 1;
                    if (is_br) begin e_b = 1; e_bd = dest; end
                    else begin e_j = 1; e_jd = dest; end
                end else begin
                    nxt_valid = 1; nxt_entry = {is_br, dest};
                end
            end else if (!bus.MemBusy) begin
                if (bus.BranchReq) begin
                    e_b = 1; e_pcw = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
                end else if (bus.LoadUse) begin
                    e_idf = 1;
                end else if (bus.JumpReq) begin
                    e_j = 1; e_pcw = 1; e_ifw = 1; e_iff = 1;
                end else begin
                    e_pcw = 1; e_ifw = 1;
                end
            end else begin
                if (bus.BranchReq) begin
                    e_ifw = 1; e_iff = 1; e_idf = 1;
                    nxt_valid = 1; nxt_entry = {1'b1, bus.BranchDestIn};
                end else if (bus.LoadUse) begin
                    e_idf = 1;
                end else begin
                    e_ifw = 1; e_iff = 1;
                    if (bus.JumpReq) begin
                        nxt_valid = 1; nxt_entry = {1'b0, bus.JumpDestIn};
                    end
                end
            end
        end
        e_pcw_c   = e_pcw;
        e_flush_c = e_iff | e_idf;
`ifdef FETCH_PERF_CNT_EN
        exp_v = {e_pcw, e_j, e_b, e_ifw, e_iff, e_idf, e_bd, e_jd, m_stall, m_flush};
`else
        exp_v = {e_pcw, e_j, e_b, e_ifw, e_iff, e_idf, e_bd, e_jd, {PERF_W{1'b0}}, {PERF_W{1'b0}}};
`endif
        act_v = {bus.PCWrite, bus.Jump, bus.Branch, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXFlush,
                 bus.BranchDest, bus.JumpDest, bus.StallCount, bus.FlushCount};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t: got 0x%h expected 0x%h", $time, act_v, exp_v);
        end
    end

    always @(posedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            m_stall <= '0;
            m_flush <= '0;
        end else begin
            exp_q.delete();
            if (nxt_valid) exp_q.push_back(nxt_entry);
            if (!e_pcw_c && m_stall != {PERF_W{1'b1}}) m_stall <= m_stall + 1'b1;
            if (e_flush_c && m_flush != {PERF_W{1'b1}}) m_flush <= m_flush + 1'b1;
        end
    end

    always @(posedge Reset) exp_q.delete();

    // ---------------- driver tasks ----------------
    task automatic drive(input logic br, input logic [DEST_W-1:0] bd, input logic jr,
                         input logic [DEST_W-1:0] jd, input logic lu, input logic mb);
        @(posedge Clock);
        #1;
        bus.BranchReq = br; bus.BranchDestIn = bd;
        bus.JumpReq = jr;   bus.JumpDestIn = jd;
        bus.LoadUse = lu;   bus.MemBusy = mb;
    endtask

    task automatic at_neg();
        @(negedge Clock);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [PERF_W-1:0] s0;
        Reset = 1'b1;
        bus.BranchReq = 0; bus.BranchDestIn = '0; bus.JumpReq = 0; bus.JumpDestIn = '0;
        bus.LoadUse = 0; bus.MemBusy = 0;
        at_neg();
        lit("reset_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
        lit("reset_ifidwrite", {31'd0, bus.IFIDWrite}, 32'd0);
        lit("reset_state", {30'd0, dbg_state}, 32'd0);
        @(posedge Clock); #1; Reset = 1'b0;

        // Idle run
        for (int i = 0; i < 10; i++) begin
            drive(0, 32'h10 + i, 0, 32'h20 + i, 0, 0);
            at_neg();
            lit("idle_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
            lit("idle_sel", {30'd0, bus.Jump, bus.Branch}, 32'd0);
        end
        lit("idle_stallcount", bus.StallCount, 32'd0);

        // Branch + load-use + jump together: branch wins
        drive(1, 32'h40, 1, 32'h99, 1, 0);
        at_neg();
        lit("all3_sel", {30'd0, bus.Jump, bus.Branch}, 32'd1);
        lit("all3_bdest", bus.BranchDest, 32'h40);
        lit("all3_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
        lit("all3_flushes", {30'd0, bus.IFIDFlush, bus.IDEXFlush}, 32'd3);

        // Load-use defers a jump by one cycle
        drive(0, 0, 1, 32'h80, 1, 0);
        at_neg();
        lit("lu_ctl", {29'd0, bus.PCWrite, bus.IFIDWrite, bus.IDEXFlush}, 32'b001);
        drive(0, 0, 1, 32'h80, 0, 0);
        at_neg();
        lit("lu_jump_sel", {30'd0, bus.Jump, bus.Branch}, 32'd2);
        lit("lu_jump_dest", bus.JumpDest, 32'h80);

        // Memory busy 3 cycles with a jump in the first
        drive(0, 0, 1, 32'h100, 0, 1);
        at_neg();
        s0 = bus.StallCount;
        lit("mb1_ctl", {30'd0, bus.PCWrite, bus.IFIDFlush}, 32'b01);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 32'h0, 0, 1);
            at_neg();
            lit("mb_wait_ctl", {30'd0, bus.PCWrite, bus.IFIDFlush}, 32'b01);
        end
        drive(0, 0, 0, 32'h0, 0, 0);
        at_neg();
        lit("replay_jump_sel", {30'd0, bus.Jump, bus.Branch}, 32'd2);
        lit("replay_jump_dest", bus.JumpDest, 32'h100);
        lit("replay_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
        drive(0, 0, 0, 32'h0, 0, 0);
        at_neg();
`ifdef FETCH_PERF_CNT_EN
        lit("stall_delta", bus.StallCount - s0, 32'd3);
`else
        lit("stall_disabled", bus.StallCount, 32'd0);
        lit("flush_disabled", bus.FlushCount, 32'd0);
`endif

        // Branch overrides a pending jump
        drive(0, 0, 1, 32'h100, 0, 1);
        drive(1, 32'h200, 1, 32'h444, 0, 1);
        at_neg();
        lit("redir_br_idex", {31'd0, bus.IDEXFlush}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        at_neg();
        lit("override_sel", {30'd0, bus.Jump, bus.Branch}, 32'd1);
        lit("override_bdest", bus.BranchDest, 32'h200);

        // Redirect arriving in a plain memory wait
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 1);
        at_neg();
        lit("busy_lu_ctl", {29'd0, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXFlush}, 32'b001);
        drive(1, 32'h44, 0, 0, 0, 1);
        drive(0, 32'h7, 0, 0, 0, 0);
        at_neg();
        lit("waitmem_br_dest", bus.BranchDest, 32'h44);

        // Reset in WAIT_REDIR drops the pending jump
        drive(0, 0, 1, 32'h300, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        #2; Reset = 1'b1; #1;
        lit("rst_async_ctl", {26'd0, bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXFlush,
                              bus.Jump, bus.Branch}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        bus.MemBusy = 0; bus.JumpDestIn = 32'h55;
        at_neg();
        lit("post_rst_sel", {30'd0, bus.Jump, bus.Branch}, 32'd0);
        lit("post_rst_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
        lit("post_rst_jdest", bus.JumpDest, 32'h55);

        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        at_neg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the instruction-fetch stage: decides each cycle whether the program counter advances, holds, or is redirected, and drives the `{Jump, Branch}` select and destination inputs of the fetch-stage PC source mux. It also drives the IF/ID and ID/EX pipeline-register write and flush controls. It arbitrates branch redirects from EX, jump redirects from ID, load-use stalls from ID, and multi-cycle instruction-memory waits. A redirect that arrives while memory is busy is captured and replayed when the wait ends.

## Interface
- `DEST_W`, 32, width of PC/destination addresses
- `PERF_W`, 32, width of performance counters

Ports:
- `Clock`  in  1  single clock, all state on rising edge
- `Reset`  in  1  asynchronous, active-high
- `BranchReq`  in  1  taken branch resolved in EX
- `BranchDestIn`  in  DEST_W  branch target
- `JumpReq`  in  1  jump decoded in ID
- `JumpDestIn`  in  DEST_W  jump target
- `LoadUse`  in  1  load-use hazard detected in ID
- `MemBusy`  in  1  instruction memory has no valid word this cycle
- `PCWrite`  out  1  PC register load enable
- `Jump`, `Branch`  out  1 each  PC source mux select; `{Jump, Branch}`: 00 = PC+4, 01 = branch, 10 = jump, 11 = never driven
- `BranchDest`, `JumpDest`  out  DEST_W  mux targets (live or replayed)
- `IFIDWrite`  out  1  IF/ID register load enable
- `IFIDFlush`  out  1  load bubble into IF/ID
- `IDEXFlush`  out  1  load bubble into ID/EX
- `StallCount`, `FlushCount`  out  PERF_W  performance counters (see Configuration)

## Operation
- States: RUN, WAIT_MEM, WAIT_REDIR.
- Priority: `BranchReq` > `LoadUse` > `JumpReq`.
  - A branch squashes both the ID and IF instructions.
  - A jump under load-use is deferred, because ID holds and the jump re-asserts next cycle.

RUN, `MemBusy` = 0:
- Branch: `Branch`=1, `PCWrite`=1, `IFIDFlush`=1, `IDEXFlush`=1.
- Else load-use: `PCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1.
- Else jump: `Jump`=1, `PCWrite`=1, `IFIDFlush`=1.
- Else: `PCWrite`=1, `IFIDWrite`=1, select 00.

RUN, `MemBusy` = 1:
- `PCWrite`=0.
- If `LoadUse`: `IFIDWrite`=0, `IDEXFlush`=1. Otherwise `IFIDWrite`=1 and `IFIDFlush`=1, so a bubble enters ID.
- If a branch or jump is also present, apply the same flushes as above, latch the kind and target into the pending register, and go to WAIT_REDIR. Otherwise go to WAIT_MEM.

WAIT_MEM:
- Same outputs as RUN with `MemBusy`=1.
- A redirect arriving here is latched and moves the state to WAIT_REDIR.
- `MemBusy`=0 → behave as RUN this cycle and return to RUN.

WAIT_REDIR:
- `PCWrite`=0, `IFIDWrite`=1, `IFIDFlush`=1.
- A new `BranchReq` overwrites the pending entry and flushes ID/EX. `JumpReq` is ignored, since ID holds only bubbles.
- `MemBusy`=0 → drive the pending select and target with `PCWrite`=1 and `IFIDFlush`=1, then go to RUN.

Target outputs:
- `BranchDest`/`JumpDest` pass the inputs through, except in the replay cycle, when the latched target is driven on the matching output.

## Timing
- Control outputs are combinational from state and inputs, with zero-cycle latency in RUN.
- A pending redirect takes effect on the first cycle with `MemBusy`=0. The PC holds the target after that edge.
- While `Reset` is high, and immediately on its assertion:
  - `PCWrite`=0, `IFIDWrite`=0, all flushes 0, `Jump`=`Branch`=0.
  - Dest outputs pass through inputs; pending register cleared to 0.
  - State RUN, counters 0.
- Reset mid-WAIT_REDIR drops the pending redirect.
- Simultaneous branch, load-use and jump: the branch wins, and no stall cycle is charged.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `StallCount` increments on every cycle with `PCWrite`=0 outside reset.
  - `FlushCount` increments on every cycle with `IFIDFlush` or `IDEXFlush` high.
  - Both counters saturate at all-ones.
- Undefined: both outputs are constant 0 and no counter flops are built.

## Structure
- Shared package `icarus_fetch_pkg` holds:
  - the state enum (RUN=0, WAIT_MEM=1, WAIT_REDIR=2);
  - the select constants `SEL_SEQ`=2'b00, `SEL_BRANCH`=2'b01, `SEL_JUMP`=2'b10;
  - the pending-kind encoding.
- One sub-module, `sat_counter` (parameter width, inc, clear), instantiated twice under the macro.

## Test plan
- Idle run, no requests → `PCWrite`=1 every cycle, select 00, no flushes, `StallCount`=0 after 10 cycles.
- `BranchReq`=1, `JumpReq`=1, `LoadUse`=1, `BranchDestIn`=0x40 in one cycle → `Branch`=1, `Jump`=0, `BranchDest`=0x40, `PCWrite`=1, both flushes 1.
- `LoadUse` one cycle with `JumpReq` → cycle 1: `PCWrite`=0, `IFIDWrite`=0, `IDEXFlush`=1. Cycle 2 with jump to 0x80: `Jump`=1, `JumpDest`=0x80.
- `MemBusy` for 3 cycles, `JumpReq` to 0x100 in the first → 3 cycles with `PCWrite`=0 and `IFIDFlush`=1. Fourth cycle: `Jump`=1, `JumpDest`=0x100, `PCWrite`=1. With the macro, `StallCount`=3.
- In WAIT_REDIR with jump 0x100 pending, `BranchReq` to 0x200 → replay drives `Branch`=1, `BranchDest`=0x200, and the jump is dropped.
- `Reset` asserted in WAIT_REDIR → outputs reach reset values immediately. After release with `MemBusy`=0, select 00 and no replay.
